// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the Wishbone bus arbiter: state encodings, fetch byte select and the
// default timeout length used when WB_ARB_TIMEOUT_EN is defined.
package wb_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StIfBusy    = 3'd1,
    StMemBusy   = 3'd2,
    StFlushWait = 3'd3,
    StAck       = 3'd4
  } arb_state_e;

  localparam logic [3:0] FetchSel = 4'hF;

  localparam int unsigned DefaultTimeoutCycles = 256;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the last allowed one.
// Only instantiated by wb_bus_arbiter when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog #(
  parameter int unsigned Cycles = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expire on the Cycles-th enabled cycle after a clear.
  assign expire = en & ~clr & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares one Wishbone master port between fetch (IF) and data (MEM), MEM first.
// Optional bus timeout with WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        stallreq_if_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stallreq_mem_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        bus_err_o
);

  arb_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        grant;
  logic        timeout_expire;

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_en;
  assign wd_en = (state_q == StIfBusy) || (state_q == StMemBusy) || (state_q == StFlushWait);

  wb_arb_watchdog #(
    .Cycles(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant),
    .en    (wd_en),
    .expire(timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, grant};
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = 1'b0;
    grant       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!flush_i) begin
          if (mem_req_i) begin
            grant   = 1'b1;
            cyc_d   = 1'b1;
            we_d    = mem_we_i;
            sel_d   = mem_sel_i;
            adr_d   = mem_addr_i;
            dat_d   = mem_wdata_i;
            state_d = StMemBusy;
          end else if (if_req_i) begin
            grant   = 1'b1;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = FetchSel;
            adr_d   = if_addr_i;
            dat_d   = '0;
            state_d = StIfBusy;
          end
        end
      end
      StIfBusy, StMemBusy: begin
        if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            state_d = StAck;
            if (state_q == StIfBusy) begin
              if_ack_d   = 1'b1;
              if_rdata_d = wb_dat_i;
            end else begin
              mem_ack_d   = 1'b1;
              mem_rdata_d = wb_dat_i;
            end
          end
        end else if (timeout_expire) begin
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end else if (flush_i) begin
          // Let the slave finish; its result is thrown away in StFlushWait.
          state_d = StFlushWait;
        end
      end
      StFlushWait: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = StIdle;
        end else if (timeout_expire) begin
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_sel_o       = sel_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign if_ack_o       = if_ack_q;
  assign mem_ack_o      = mem_ack_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign bus_err_o      = bus_err_q;
  assign stallreq_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized request mixes
// against a scoreboard of expected bus transactions and read data.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        stallreq_if_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        stallreq_mem_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        bus_err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  // Slave model: acks slave_lat cycles after cyc/stb rises (negative = never).
  int          slave_lat   = 0;
  logic        slave_fixed = 1'b0;
  logic [31:0] slave_data  = '0;
  logic        slave_ack   = 1'b0;
  logic        force_ack   = 1'b0;
  int          slave_cnt   = 0;
  txn_t        mon_q[$];

  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;

  assign wb_ack_i = slave_ack | force_ack;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_rdata_o    (if_rdata_o),
    .if_ack_o      (if_ack_o),
    .stallreq_if_o (stallreq_if_o),
    .mem_req_i     (mem_req_i),
    .mem_we_i      (mem_we_i),
    .mem_sel_i     (mem_sel_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_rdata_o   (mem_rdata_o),
    .mem_ack_o     (mem_ack_o),
    .stallreq_mem_o(stallreq_mem_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .bus_err_o     (bus_err_o)
  );

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always begin
    txn_t t;
    @(posedge clk);
    #1;
    slave_ack = 1'b0;
    if (rst || !(wb_cyc_o && wb_stb_o)) begin
      slave_cnt = 0;
    end else if (slave_lat >= 0 && slave_cnt >= slave_lat) begin
      slave_ack = 1'b1;
      wb_dat_i  = slave_fixed ? slave_data : resp_data(wb_adr_o);
      t.we  = wb_we_o;
      t.sel = wb_sel_o;
      t.adr = wb_adr_o;
      t.dat = wb_dat_o;
      mon_q.push_back(t);
      slave_cnt = 0;
    end else begin
      slave_cnt++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, if_ack_o, mem_ack_o,
         bus_err_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h ack=%b%b err=%b, want 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, if_ack_o, mem_ack_o,
               bus_err_o);
    end
    tests_run++;
    if ({if_rdata_o, mem_rdata_o} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: if=%h mem=%h, want 0", if_rdata_o, mem_rdata_o);
    end
    rst = 1'b0;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    tick();
  endtask

  task automatic test_if_only();
    bit got = 0;
    slave_fixed = 1'b1;
    slave_data  = 32'h3C01_1234;
    slave_lat   = 2;
    if_addr_i   = 32'h0000_0100;
    if_req_i    = 1'b1;
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
        {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0}) begin
      tests_failed++;
      $display("FAIL if_grant: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want 1 1 0 f 100 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
    end
    tests_run++;
    if (stallreq_if_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL if_stall_wait: got %b want 1", stallreq_if_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_ack_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL if_ack_timeout: no if_ack_o within 20 cycles");
    end
    tests_run++;
    if ({if_rdata_o, stallreq_if_o, wb_cyc_o} !== {32'h3C01_1234, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL if_ack_cycle: rdata=%h stall=%b cyc=%b, want 3c011234 0 0",
               if_rdata_o, stallreq_if_o, wb_cyc_o);
    end
    exp_if_rdata = 32'h3C01_1234;
    if_req_i = 1'b0;
    tick();
    tests_run++;
    if (if_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL if_ack_pulse: ack still %b, want 0", if_ack_o);
    end
    slave_fixed = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] base = 32'h0001_0000;
    slave_lat = 0;
    if_addr_i = base;
    if_req_i  = 1'b1;
    // Held request: grants land every 3 cycles (busy, ack, idle).
    for (int k = 0; k < 9; k++) begin
      tick();
      tests_run++;
      if (wb_cyc_o !== (k % 3 == 0) || if_ack_o !== (k % 3 == 1)) begin
        tests_failed++;
        $display("FAIL b2b_spacing k=%0d: cyc=%b ack=%b, want %b %b", k, wb_cyc_o, if_ack_o,
                 k % 3 == 0, k % 3 == 1);
      end
      if (k % 3 == 0) begin
        tests_run++;
        if (wb_adr_o !== base + 32'(4 * (k / 3))) begin
          tests_failed++;
          $display("FAIL b2b_adr k=%0d: got %h want %h", k, wb_adr_o, base + 32'(4 * (k / 3)));
        end
      end
      if (k % 3 == 1) begin
        exp_if_rdata = resp_data(base + 32'(4 * (k / 3)));
        tests_run++;
        if (if_rdata_o !== exp_if_rdata) begin
          tests_failed++;
          $display("FAIL b2b_rdata k=%0d: got %h want %h", k, if_rdata_o, exp_if_rdata);
        end
        if_addr_i = if_addr_i + 32'd4;
      end
    end
    if_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_contention();
    slave_lat   = 0;
    mem_we_i    = 1'b1;
    mem_sel_i   = 4'b0011;
    mem_addr_i  = 32'h0000_0080;
    mem_wdata_i = 32'hDEAD_BEEF;
    if_addr_i   = 32'h0000_0200;
    mem_req_i   = 1'b1;
    if_req_i    = 1'b1;
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'h0000_0080, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL cont_mem_first: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want 1 1 1 3 80 deadbeef",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
    end
    tick();
    exp_mem_rdata = resp_data(32'h0000_0080);
    tests_run++;
    if ({mem_ack_o, mem_rdata_o, stallreq_mem_o, stallreq_if_o} !==
        {1'b1, exp_mem_rdata, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL cont_mem_ack: ack=%b rdata=%h stall_mem=%b stall_if=%b, want 1 %h 0 1",
               mem_ack_o, mem_rdata_o, stallreq_mem_o, stallreq_if_o, exp_mem_rdata);
    end
    mem_req_i = 1'b0;
    tick();
    tests_run++;
    if ({wb_cyc_o, stallreq_if_o} !== 2'b01) begin
      tests_failed++;
      $display("FAIL cont_ack_gap: cyc=%b stall_if=%b, want 0 1", wb_cyc_o, stallreq_if_o);
    end
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, stallreq_if_o} !==
        {1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL cont_if_second: cyc=%b we=%b sel=%h adr=%h dat=%h stall_if=%b, want 1 0 f 200 0 1",
               wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, stallreq_if_o);
    end
    tick();
    exp_if_rdata = resp_data(32'h0000_0200);
    tests_run++;
    if ({if_ack_o, if_rdata_o, stallreq_if_o} !== {1'b1, exp_if_rdata, 1'b0}) begin
      tests_failed++;
      $display("FAIL cont_if_ack: ack=%b rdata=%h stall=%b, want 1 %h 0",
               if_ack_o, if_rdata_o, stallreq_if_o, exp_if_rdata);
    end
    if_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush_in_flight();
    bit got = 0;
    slave_lat   = 3;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'hF;
    mem_addr_i  = 32'h0000_0300;
    mem_wdata_i = 32'h0;
    mem_req_i   = 1'b1;
    tick();
    flush_i   = 1'b1;
    mem_req_i = 1'b0;
    if_addr_i = 32'h0000_0400;
    if_req_i  = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({wb_cyc_o, wb_adr_o, mem_ack_o} !== {1'b1, 32'h0000_0300, 1'b0}) begin
        tests_failed++;
        $display("FAIL flush_hold k=%0d: cyc=%b adr=%h mem_ack=%b, want 1 300 0",
                 k, wb_cyc_o, wb_adr_o, mem_ack_o);
      end
      tick();
    end
    tests_run++;
    if ({wb_cyc_o, mem_ack_o, if_ack_o, mem_rdata_o} !== {3'b000, exp_mem_rdata}) begin
      tests_failed++;
      $display("FAIL flush_discard: cyc=%b mem_ack=%b if_ack=%b mem_rdata=%h, want 0 0 0 %h",
               wb_cyc_o, mem_ack_o, if_ack_o, mem_rdata_o, exp_mem_rdata);
    end
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h0000_0400}) begin
      tests_failed++;
      $display("FAIL flush_next_grant: cyc=%b adr=%h, want 1 400", wb_cyc_o, wb_adr_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_ack_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    exp_if_rdata = resp_data(32'h0000_0400);
    tests_run++;
    if (!got || if_rdata_o !== exp_if_rdata) begin
      tests_failed++;
      $display("FAIL flush_if_after: acked=%0d rdata=%h, want 1 %h", got, if_rdata_o, exp_if_rdata);
    end
    if_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_flush_with_ack();
    slave_lat  = 1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0500;
    mem_req_i  = 1'b1;
    tick();
    tick();
    flush_i   = 1'b1;
    mem_req_i = 1'b0;
    tick();
    flush_i = 1'b0;
    tests_run++;
    if ({wb_cyc_o, mem_ack_o, mem_rdata_o} !== {2'b00, exp_mem_rdata}) begin
      tests_failed++;
      $display("FAIL flush_ack_same: cyc=%b mem_ack=%b rdata=%h, want 0 0 %h",
               wb_cyc_o, mem_ack_o, mem_rdata_o, exp_mem_rdata);
    end
    slave_lat  = 0;
    mem_addr_i = 32'h0000_0600;
    mem_req_i  = 1'b1;
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h0000_0600}) begin
      tests_failed++;
      $display("FAIL flush_ack_idle: cyc=%b adr=%h, want 1 600", wb_cyc_o, wb_adr_o);
    end
    tick();
    exp_mem_rdata = resp_data(32'h0000_0600);
    tests_run++;
    if ({mem_ack_o, mem_rdata_o} !== {1'b1, exp_mem_rdata}) begin
      tests_failed++;
      $display("FAIL flush_ack_resume: ack=%b rdata=%h, want 1 %h",
               mem_ack_o, mem_rdata_o, exp_mem_rdata);
    end
    mem_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    slave_lat   = -1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h0000_0700;
    mem_wdata_i = 32'h1234_5678;
    mem_req_i   = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({wb_cyc_o, wb_stb_o, if_ack_o, mem_ack_o, bus_err_o, if_rdata_o, mem_rdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: cyc=%b stb=%b ack=%b%b err=%b rdata=%h/%h, want all 0",
               wb_cyc_o, wb_stb_o, if_ack_o, mem_ack_o, bus_err_o, if_rdata_o, mem_rdata_o);
    end
    rst           = 1'b0;
    mem_req_i     = 1'b0;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    force_ack     = 1'b1;
    wb_dat_i      = 32'hBAD0_BAD0;
    tick();
    force_ack = 1'b0;
    tick();
    tests_run++;
    if ({wb_cyc_o, if_ack_o, mem_ack_o, mem_rdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL stray_ack: cyc=%b ack=%b%b mem_rdata=%h, want 0",
               wb_cyc_o, if_ack_o, mem_ack_o, mem_rdata_o);
    end
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    slave_lat  = -1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0900;
    mem_req_i  = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) begin
      tick();
      tests_run++;
      if ({bus_err_o, wb_cyc_o} !== 2'b01) begin
        tests_failed++;
        $display("FAIL timeout_wait k=%0d: err=%b cyc=%b, want 0 1", k, bus_err_o, wb_cyc_o);
      end
    end
    tick();
    tests_run++;
    if ({bus_err_o, wb_cyc_o, mem_ack_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL timeout_fire: err=%b cyc=%b ack=%b, want 1 0 0", bus_err_o, wb_cyc_o, mem_ack_o);
    end
    mem_req_i = 1'b0;
    tick();
    tests_run++;
    if (bus_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: err=%b, want 0", bus_err_o);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    txn_t exp_q[$];
    txn_t t;
    bit   use_if, use_mem, if_done, mem_done;
    int   mode;
    for (int it = 0; it < 40; it++) begin
      mode        = $urandom_range(0, 2);
      use_if      = (mode != 1);
      use_mem     = (mode != 0);
      slave_lat   = $urandom_range(0, 4);
      if_addr_i   = $urandom & 32'hFFFF_FFFC;
      mem_we_i    = 1'($urandom_range(0, 1));
      mem_sel_i   = 4'($urandom_range(1, 15));
      mem_addr_i  = $urandom & 32'hFFFF_FFFC;
      mem_wdata_i = $urandom;
      exp_q.delete();
      mon_q.delete();
      if (use_mem) begin
        t = '{we: mem_we_i, sel: mem_sel_i, adr: mem_addr_i, dat: mem_wdata_i};
        exp_q.push_back(t);
      end
      if (use_if) begin
        t = '{we: 1'b0, sel: 4'hF, adr: if_addr_i, dat: 32'h0};
        exp_q.push_back(t);
      end
      mem_req_i = use_mem;
      if_req_i  = use_if;
      if_done   = !use_if;
      mem_done  = !use_mem;
      for (int c = 0; c < 80 && !(if_done && mem_done); c++) begin
        tick();
        tests_run++;
        if (stallreq_if_o !== (!if_done && !if_ack_o) ||
            stallreq_mem_o !== (!mem_done && !mem_ack_o)) begin
          tests_failed++;
          $display("FAIL rand_stall it=%0d c=%0d: if=%b mem=%b", it, c, stallreq_if_o,
                   stallreq_mem_o);
        end
        if (if_ack_o === 1'b1) begin
          tests_run++;
          if (if_done || (use_mem && !mem_done) || if_rdata_o !== resp_data(if_addr_i)) begin
            tests_failed++;
            $display("FAIL rand_if_ack it=%0d: rdata=%h want %h (early/extra=%0d)", it,
                     if_rdata_o, resp_data(if_addr_i), if_done || (use_mem && !mem_done));
          end
          exp_if_rdata = resp_data(if_addr_i);
          if_done  = 1;
          if_req_i = 1'b0;
        end
        if (mem_ack_o === 1'b1) begin
          tests_run++;
          if (mem_done || mem_rdata_o !== resp_data(mem_addr_i)) begin
            tests_failed++;
            $display("FAIL rand_mem_ack it=%0d: rdata=%h want %h (extra=%0d)", it,
                     mem_rdata_o, resp_data(mem_addr_i), mem_done);
          end
          exp_mem_rdata = resp_data(mem_addr_i);
          mem_done  = 1;
          mem_req_i = 1'b0;
        end
      end
      tests_run++;
      if (!(if_done && mem_done)) begin
        tests_failed++;
        $display("FAIL rand_budget it=%0d: if_done=%0d mem_done=%0d", it, if_done, mem_done);
      end
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({if_ack_o, mem_ack_o, wb_cyc_o} !== 3'b000) begin
        tests_failed++;
        $display("FAIL rand_quiet it=%0d: ack=%b%b cyc=%b", it, if_ack_o, mem_ack_o, wb_cyc_o);
      end
      tests_run++;
      if (mon_q.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL rand_txn_count it=%0d: got %0d want %0d", it, mon_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests_run++;
          if (mon_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL rand_txn it=%0d #%0d: got %h want %h", it, i, mon_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush_i     = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_sel_i   = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    wb_dat_i    = '0;
    test_reset();
    test_if_only();
    test_back_to_back();
    test_contention();
    test_flush_in_flight();
    test_flush_with_ack();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, %0d run %0d failed", tests_run,
             tests_failed);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

- Shares the core's single Wishbone master port between instruction fetch (IF) and data access (MEM).
- Latches one request at a time, runs the bus cycle, and returns read data with a one-cycle acknowledge.
- Raises per-requester stall requests toward the pipeline controller.
- Discards in-flight results when the controller flushes the pipeline on an exception.

## Interface
- TIMEOUT_CYCLES, 256: bus cycles allowed without wb_ack_i before forced termination (used only with WB_ARB_TIMEOUT_EN).
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  pipeline flush from controller
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched word, valid with if_ack_o
- if_ack_o  out  1  fetch done, 1-cycle pulse
- stallreq_if_o  out  1  fetch stall request
- mem_req_i  in  1  data request, held until mem_ack_o
- mem_we_i  in  1  1 = write
- mem_sel_i  in  4  byte lanes
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data, valid with mem_ack_o
- mem_ack_o  out  1  data done, 1-cycle pulse
- stallreq_mem_o  out  1  data stall request
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- bus_err_o  out  1  timeout pulse to exception logic (tied 0 without macro)

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY, FLUSH_WAIT, ACK.
- IDLE, no flush_i:
  - mem_req_i → latch mem_* onto wb_*, assert cyc/stb, go MEM_BUSY.
  - Else if_req_i → latch if_addr_i (we=0, sel=4'hF, dat=0), go IF_BUSY.
  - MEM has fixed priority because it is the older instruction.
- IDLE with flush_i: start nothing.
- IF_BUSY/MEM_BUSY on wb_ack_i, no flush_i:
  - Register wb_dat_i into the requester's rdata.
  - Pulse the requester's ack_o.
  - Drop cyc/stb, go ACK.
- IF_BUSY/MEM_BUSY on wb_ack_i with flush_i: drop cyc/stb, no ack_o, go IDLE.
- IF_BUSY/MEM_BUSY with flush_i and no ack: go FLUSH_WAIT; cyc/stb stay high (no bus abort).
- FLUSH_WAIT: on wb_ack_i, drop cyc/stb, discard data, no ack_o, go IDLE.
- ACK: one cycle, no new transaction (requester still holds req that cycle), go IDLE.
- stallreq_X_o = X_req_i & ~X_ack_o. This is combinational and also covers a requester waiting on the other.
- rdata registers hold their last value until overwritten.
- Reset: state IDLE; all wb_* outputs, ack_o, rdata_o and bus_err_o = 0.
  - Reset mid-cycle drops cyc immediately.
  - A late wb_ack_i after reset is ignored.

## Timing
- Request seen at edge N (IDLE) → cyc/stb high from N+1.
- Zero-wait slave acks at N+1 → ack_o and rdata valid at N+2, cyc low at N+2.
- Minimum spacing between grants: 3 cycles (BUSY, ACK, IDLE).
- All outputs are registered except the stallreq_* signals.
- Simultaneous if_req_i and mem_req_i: MEM is served first, and IF stall holds through both transactions.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - Counter runs while in a BUSY state or FLUSH_WAIT.
  - Reaching TIMEOUT_CYCLES with no ack → drop cyc/stb, pulse bus_err_o 1 cycle, no ack_o, go IDLE.
  - The counter clears on every grant.
- Undefined: no counter; bus_err_o constant 0; waits indefinitely.

## Structure
- Shared defines header holds:
  - State encodings (3-bit).
  - Default fetch byte select 4'hF.
  - Default TIMEOUT_CYCLES.
- One sub-module is natural: wb_arb_watchdog (timeout counter, clear/enable in, expire pulse out), instantiated only under WB_ARB_TIMEOUT_EN.

## Test plan
- IF-only: if_req_i=1, addr 0x00000100, slave acks 2 cycles after stb with 0x3C011234 → if_ack_o 1 cycle, if_rdata_o=0x3C011234, stallreq_if_o low same cycle.
- Contention: both requests together; MEM write addr 0x80, sel 4'b0011, data 0xDEADBEEF → MEM bus cycle first with exact wb_* values, then IF cycle; IF stalled throughout.
- Flush in flight: flush_i 1 cycle while MEM_BUSY, ack 3 cycles later → no mem_ack_o, cyc drops on ack, next grant only after IDLE.
- Flush with ack same cycle → data discarded, no ack_o, state IDLE.
- Reset mid-transaction: rst while cyc high → cyc/stb/ack_o 0 next edge; stray wb_ack_i ignored.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks → bus_err_o pulses 8 cycles after grant, cyc drops, no ack_o.
